uart_frame_ctrl: RTL and testbench

Byte-level frame controller that sits directly behind the UART receiver in the RS232 path. It consumes received bytes (data plus one-cycle received strobe), finds a sync byte, and parses a command/length/payload/checksum frame. Payload bytes are streamed into an external buffer, and each completed frame is presented to the host logic with a hold-until-acknowledge handshake. Malformed, timed-out or overrunning traffic is reported as an error pulse with a code.

---
 rtl/uart_frame_pkg.sv | 24 ++
 rtl/uart_rx_timeout.sv | 42 ++++
 rtl/uart_frame_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
//   Shared definitions for the UART frame controller:
//   - state_t      : 3-bit frame parser state encoding
//   - ERR_*        : error codes reported on oERR_CODE
//   - SYNC_BYTE_DEFAULT : default frame start marker
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_timeout.sv
// uart_rx_timeout
//   Inter-byte timeout counter. Counts tick pulses while enabled; a tick that
//   arrives with the count at TICKS-1 produces a single-cycle expire pulse and
//   wraps the count. clr (or en low) holds the count at zero, and a cleared
//   cycle never expires, so a byte arriving with the expiring tick wins.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   clr     in   clear the count (new byte / not in a timed state)
//   en      in   counting enabled
//   tick    in   time base pulse
//   expire  out  combinational, high for the cycle of the expiring tick
module uart_rx_timeout #(
  parameter int TICKS = 4096,
  parameter int W     = (TICKS > 1) ? $clog2(TICKS) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || !en) begin
      cnt_reg <= '0;
    end else if (tick) begin
      if (cnt_reg == LAST) cnt_reg <= '0;
      else                 cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign expire = en && !clr && tick && (cnt_reg == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
//   Parses SYNC, CMD, LEN, payload, CHK frames from a UART byte stream.
//   Payload bytes are streamed to an external buffer; a good frame is held
//   (oFRAME_VALID) until iACK. Errors pulse oERR with a sticky oERR_CODE.
// Ports:
//   iCLK_50          in   system clock
//   iRST_N           in   asynchronous active-low reset
//   iRX_TICK         in   one-cycle strobe, iRX_DATA holds a new byte
//   iRX_DATA[7:0]    in   received byte
//   iBAUD_RATE_TICK  in   oversample tick, timeout time base
//   iACK             in   host consumed the presented frame
//   oWR_EN           out  payload write strobe (one cycle)
//   oWR_ADDR[AW-1:0] out  payload index
//   oWR_DATA[7:0]    out  payload byte
//   oCMD[7:0]        out  command of last good frame
//   oLEN[7:0]        out  payload length of last good frame
//   oFRAME_VALID     out  high from frame completion until acknowledged
//   oERR             out  one-cycle error pulse
//   oERR_CODE[1:0]   out  error code, held after the pulse
//   oBUSY            out  parser not idle
// MAX_LEN must be a power of two between 2 and 128 so that AW >= 1 and the
// internal index (AW+1 bits) fits in a byte.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN       = 16,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_TICKS = 4096,
  parameter int         AW            = $clog2(MAX_LEN)
) (
  input  logic          iCLK_50,
  input  logic          iRST_N,
  input  logic          iRX_TICK,
  input  logic [7:0]    iRX_DATA,
  input  logic          iBAUD_RATE_TICK,
  input  logic          iACK,
  output logic          oWR_EN,
  output logic [AW-1:0] oWR_ADDR,
  output logic [7:0]    oWR_DATA,
  output logic [7:0]    oCMD,
  output logic [7:0]    oLEN,
  output logic          oFRAME_VALID,
  output logic          oERR,
  output logic [1:0]    oERR_CODE,
  output logic          oBUSY
);

  localparam int         IW        = AW + 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t         state_reg, state_next;
  logic [7:0]     cmd_reg, cmd_next;
  logic [7:0]     len_reg, len_next;
  logic [7:0]     sum_reg, sum_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic           wr_en_reg, wr_en_next;
  logic [AW-1:0]  wr_addr_reg, wr_addr_next;
  logic [7:0]     wr_data_reg, wr_data_next;
  logic [7:0]     out_cmd_reg, out_cmd_next;
  logic [7:0]     out_len_reg, out_len_next;
  logic           err_reg, err_next;
  logic [1:0]     err_code_reg, err_code_next;

  logic           timed_state;
  logic           timeout_expire;
  logic [7:0]     chk_sum;

  // Every entry into a timed state happens on a received byte, so clearing
  // on iRX_TICK (and while untimed) also covers the clear-on-entry rule.
  assign timed_state = (state_reg == ST_CMD) || (state_reg == ST_LEN) ||
                       (state_reg == ST_PAYLOAD) || (state_reg == ST_CHK);

  uart_rx_timeout #(
    .TICKS (TIMEOUT_TICKS)
  ) u_timeout (
    .clk    (iCLK_50),
    .rst_n  (iRST_N),
    .clr    (iRX_TICK),
    .en     (timed_state),
    .tick   (iBAUD_RATE_TICK),
    .expire (timeout_expire)
  );

  assign chk_sum = sum_reg + iRX_DATA;

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      len_reg      <= '0;
      sum_reg      <= '0;
      idx_reg      <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      out_cmd_reg  <= '0;
      out_len_reg  <= '0;
      err_reg      <= 1'b0;
      err_code_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      len_reg      <= len_next;
      sum_reg      <= sum_next;
      idx_reg      <= idx_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      out_cmd_reg  <= out_cmd_next;
      out_len_reg  <= out_len_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    len_next      = len_reg;
    sum_next      = sum_reg;
    idx_next      = idx_reg;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    out_cmd_next  = out_cmd_reg;
    out_len_next  = out_len_reg;
    err_next      = 1'b0;
    err_code_next = err_code_reg;

    case (state_reg)
      ST_IDLE: begin
        if (iRX_TICK && (iRX_DATA == SYNC_BYTE)) state_next = ST_CMD;
      end

      ST_CMD: begin
        if (iRX_TICK) begin
          cmd_next   = iRX_DATA;
          sum_next   = iRX_DATA;
          state_next = ST_LEN;
        end else if (timeout_expire) begin
          err_next      = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = ST_IDLE;
        end
      end

      ST_LEN: begin
        if (iRX_TICK) begin
          if (iRX_DATA > MAX_LEN_B) begin
            err_next      = 1'b1;
            err_code_next = ERR_LEN;
            state_next    = ST_IDLE;
          end else begin
            len_next   = iRX_DATA;
            sum_next   = sum_reg + iRX_DATA;
            idx_next   = '0;
            state_next = (iRX_DATA == 8'd0) ? ST_CHK : ST_PAYLOAD;
          end
        end else if (timeout_expire) begin
          err_next      = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = ST_IDLE;
        end
      end

      ST_PAYLOAD: begin
        if (iRX_TICK) begin
          wr_en_next   = 1'b1;
          wr_addr_next = idx_reg[AW-1:0];
          wr_data_next = iRX_DATA;
          sum_next     = sum_reg + iRX_DATA;
          idx_next     = idx_reg + IW'(1);
          // Byte just written is the last one of the payload.
          if (8'(idx_reg) == (len_reg - 8'd1)) state_next = ST_CHK;
        end else if (timeout_expire) begin
          err_next      = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = ST_IDLE;
        end
      end

      ST_CHK: begin
        if (iRX_TICK) begin
          if (chk_sum == 8'd0) begin
            out_cmd_next = cmd_reg;
            out_len_next = len_reg;
            state_next   = ST_HOLD;
          end else begin
            err_next      = 1'b1;
            err_code_next = ERR_CHK;
            state_next    = ST_IDLE;
          end
        end else if (timeout_expire) begin
          err_next      = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = ST_IDLE;
        end
      end

      ST_HOLD: begin
        // A byte arriving while the host still owns the frame is lost,
        // even when it lands in the same cycle as the acknowledge.
        if (iRX_TICK) begin
          err_next      = 1'b1;
          err_code_next = ERR_OVERRUN;
        end
        if (iACK) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign oWR_EN       = wr_en_reg;
  assign oWR_ADDR     = wr_addr_reg;
  assign oWR_DATA     = wr_data_reg;
  assign oCMD         = out_cmd_reg;
  assign oLEN         = out_len_reg;
  assign oFRAME_VALID = (state_reg == ST_HOLD);
  assign oERR         = err_reg;
  assign oERR_CODE    = err_code_reg;
  assign oBUSY        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl
//   Randomized and directed stimulus against a byte-level frame model.
//   The model tracks the current frame as a queue of received bytes and
//   derives each field from its position in the frame.
module tb_uart_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       baud = 1'b0;
  logic       ack = 1'b0;

  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] cmd_o;
  logic [7:0] len_o;
  logic       frame_valid;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  uart_frame_ctrl dut (
    .iCLK_50         (clk),
    .iRST_N          (rst_n),
    .iRX_TICK        (rx_tick),
    .iRX_DATA        (rx_data),
    .iBAUD_RATE_TICK (baud),
    .iACK            (ack),
    .oWR_EN          (wr_en),
    .oWR_ADDR        (wr_addr),
    .oWR_DATA        (wr_data),
    .oCMD            (cmd_o),
    .oLEN            (len_o),
    .oFRAME_VALID    (frame_valid),
    .oERR            (err),
    .oERR_CODE       (err_code),
    .oBUSY           (busy)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_active = 0;   // inside a frame (after SYNC, before CHK)
  bit         m_hold = 0;     // good frame waiting for ack
  logic [7:0] fr[$];          // CMD, LEN, payload bytes received so far
  int         m_sil = 0;      // baud ticks since last byte
  logic [7:0] m_cmd = 0, m_len = 0;
  bit         m_wr_en = 0;
  logic [3:0] m_wr_addr = 0;
  logic [7:0] m_wr_data = 0;
  bit         m_err = 0;
  logic [1:0] m_code = 0;

  // DUT-side observation for the directed literal checks
  logic [11:0] wr_log[$];
  int          err_count = 0;
  logic [1:0]  last_code = 0;

  always @(posedge clk) begin : model_blk
    int pos;
    int s;
    if (!rst_n) begin
      m_active = 0; m_hold = 0; fr.delete(); m_sil = 0;
      m_cmd = 0; m_len = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
      m_err = 0; m_code = 0;
    end else begin
      m_wr_en = 0;
      m_err = 0;
      if (m_hold) begin
        if (rx_tick) begin m_err = 1; m_code = 2'd3; end
        if (ack) m_hold = 0;
      end else if (!m_active) begin
        if (rx_tick && rx_data == 8'hA5) begin
          m_active = 1; fr.delete(); m_sil = 0;
        end
      end else if (rx_tick) begin
        m_sil = 0;
        pos = fr.size();
        if (pos == 0) begin
          fr.push_back(rx_data);
        end else if (pos == 1) begin
          if (rx_data > 8'd16) begin
            m_err = 1; m_code = 2'd2; m_active = 0;
          end else begin
            fr.push_back(rx_data);
          end
        end else if (pos < int'(fr[1]) + 2) begin
          m_wr_en = 1; m_wr_addr = 4'(pos - 2); m_wr_data = rx_data;
          fr.push_back(rx_data);
        end else begin
          s = int'(rx_data);
          foreach (fr[i]) s += int'(fr[i]);
          if (s % 256 == 0) begin
            m_cmd = fr[0]; m_len = fr[1]; m_hold = 1;
          end else begin
            m_err = 1; m_code = 2'd1;
          end
          m_active = 0;
        end
      end else if (baud) begin
        if (m_sil == 4095) begin
          m_err = 1; m_code = 2'd0; m_active = 0;
        end else begin
          m_sil++;
        end
      end
    end
    #1;
    chk("busy", 32'(busy), 32'(m_active || m_hold));
    chk("frame_valid", 32'(frame_valid), 32'(m_hold));
    chk("cmd", 32'(cmd_o), 32'(m_cmd));
    chk("len", 32'(len_o), 32'(m_len));
    chk("wr_en", 32'(wr_en), 32'(m_wr_en));
    if (m_wr_en) begin
      chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      chk("wr_data", 32'(wr_data), 32'(m_wr_data));
    end
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    if (wr_en) wr_log.push_back({wr_addr, wr_data});
    if (err) begin err_count++; last_code = err_code; end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic rnd_baud();
    return ($urandom_range(0, 7) == 0);
  endfunction

  // Leaves rx_tick high so consecutive calls give back-to-back bytes.
  task automatic send_byte(input logic [7:0] d, input int gap);
    @(negedge clk);
    rx_tick = 1'b1; rx_data = d; baud = rnd_baud(); ack = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      rx_tick = 1'b0; baud = rnd_baud();
    end
  endtask

  task automatic end_burst();
    @(negedge clk);
    rx_tick = 1'b0; baud = 1'b0; ack = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], 0);
    end_burst();
  endtask

  task automatic do_ack(input bit with_byte, input logic [7:0] d);
    @(negedge clk);
    ack = 1'b1; rx_tick = with_byte; rx_data = d; baud = 1'b0;
    @(negedge clk);
    ack = 1'b0; rx_tick = 1'b0;
  endtask

  task automatic baud_run(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_tick = 1'b0; baud = 1'b1;
    end
    @(negedge clk);
    baud = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_tick = 1'b0; baud = rnd_baud(); ack = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] q[$];
    logic [7:0] s;
    logic [7:0] b;
    int         e0;
    int         r;
    int         n_to;
    int         plen;

    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset valid", 32'(frame_valid), 32'd0);
    chk("reset cmd", 32'(cmd_o), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Frame with three payload bytes
    wr_log.delete();
    q = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    send_bytes(q);
    $display("[TB] directed: good frame cmd=10 len=3");
    chk("f1 writes", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      chk("f1 w0", 32'(wr_log[0]), 32'h011);
      chk("f1 w1", 32'(wr_log[1]), 32'h122);
      chk("f1 w2", 32'(wr_log[2]), 32'h233);
    end
    chk("f1 valid", 32'(frame_valid), 32'd1);
    chk("f1 cmd", 32'(cmd_o), 32'h10);
    chk("f1 len", 32'(len_o), 32'h03);
    do_ack(1'b0, 8'h00);
    chk("f1 ack busy", 32'(busy), 32'd0);
    chk("f1 ack valid", 32'(frame_valid), 32'd0);

    // Zero-length frame after leading garbage
    wr_log.delete();
    q = {8'h00, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'hFF};
    send_bytes(q);
    $display("[TB] directed: empty frame cmd=01 after garbage");
    chk("f2 writes", 32'(wr_log.size()), 32'd0);
    chk("f2 valid", 32'(frame_valid), 32'd1);
    chk("f2 cmd", 32'(cmd_o), 32'h01);
    chk("f2 len", 32'(len_o), 32'h00);
    do_ack(1'b0, 8'h00);

    // Bad checksum
    e0 = err_count;
    q = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88};
    send_bytes(q);
    $display("[TB] directed: bad checksum");
    chk("f3 errs", 32'(err_count - e0), 32'd1);
    chk("f3 code", 32'(last_code), 32'd1);
    chk("f3 valid", 32'(frame_valid), 32'd0);
    chk("f3 cmd kept", 32'(cmd_o), 32'h01);
    chk("f3 len kept", 32'(len_o), 32'h00);

    // Oversized length
    e0 = err_count;
    wr_log.delete();
    q = {8'hA5, 8'h10, 8'h11};
    send_bytes(q);
    $display("[TB] directed: length 17");
    chk("f4 errs", 32'(err_count - e0), 32'd1);
    chk("f4 code", 32'(last_code), 32'd2);
    chk("f4 writes", 32'(wr_log.size()), 32'd0);
    chk("f4 busy", 32'(busy), 32'd0);

    // Timeout after CMD
    e0 = err_count;
    q = {8'hA5, 8'h10};
    foreach (q[i]) send_byte(q[i], 0);
    baud_run(4095);
    $display("[TB] directed: timeout");
    chk("to early errs", 32'(err_count - e0), 32'd0);
    chk("to early busy", 32'(busy), 32'd1);
    baud_run(1);
    chk("to errs", 32'(err_count - e0), 32'd1);
    chk("to code", 32'(last_code), 32'd0);
    chk("to busy", 32'(busy), 32'd0);
    wr_log.delete();
    q = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    send_bytes(q);
    chk("to next valid", 32'(frame_valid), 32'd1);
    chk("to next writes", 32'(wr_log.size()), 32'd3);

    // Overrun while holding, then ack coinciding with another byte
    e0 = err_count;
    q = {8'h55};
    send_bytes(q);
    $display("[TB] directed: overrun in hold");
    chk("ov errs", 32'(err_count - e0), 32'd1);
    chk("ov code", 32'(last_code), 32'd3);
    chk("ov valid", 32'(frame_valid), 32'd1);
    chk("ov cmd", 32'(cmd_o), 32'h10);
    chk("ov len", 32'(len_o), 32'h03);
    do_ack(1'b1, 8'h66);
    chk("ov ack errs", 32'(err_count - e0), 32'd2);
    chk("ov ack valid", 32'(frame_valid), 32'd0);

    // Reset in the middle of the payload
    e0 = err_count;
    q = {8'hA5, 8'h20, 8'h05, 8'h11, 8'h22};
    foreach (q[i]) send_byte(q[i], 0);
    @(negedge clk);
    rst_n = 1'b0; rx_tick = 1'b0;
    #1;
    $display("[TB] directed: reset mid payload");
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst cmd", 32'(cmd_o), 32'd0);
    chk("rst len", 32'(len_o), 32'd0);
    chk("rst code", 32'(err_code), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("rst errs", 32'(err_count - e0), 32'd0);

    // Randomized traffic
    n_to = 0;
    for (int f = 0; f < 250; f++) begin
      r = $urandom_range(0, 9);
      q.delete();
      if (r <= 6) begin
        plen = (r == 6) ? $urandom_range(17, 255) : $urandom_range(0, 16);
        q.push_back(8'hA5);
        b = 8'($urandom); q.push_back(b); s = b;
        q.push_back(8'(plen)); s = s + 8'(plen);
        if (plen <= 16) begin
          for (int i = 0; i < plen; i++) begin
            b = 8'($urandom); q.push_back(b); s = s + b;
          end
          if (r == 5) q.push_back(8'(8'd0 - s + 8'($urandom_range(1, 255))));
          else        q.push_back(8'(8'd0 - s));
        end
        $display("[TB] random %0d: frame kind %0d len %0d", f, r, plen);
        foreach (q[i]) send_byte(q[i], $urandom_range(0, 2));
        end_burst();
        idle($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
          q.delete(); q.push_back(8'($urandom));
          send_bytes(q);
        end
        do_ack($urandom_range(0, 3) == 0, 8'($urandom));
      end else if (r == 7) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        $display("[TB] random %0d: garbage %02h", f, b);
        q.push_back(b);
        send_bytes(q);
      end else if (r == 8 && n_to < 3) begin
        n_to++;
        $display("[TB] random %0d: truncated frame then silence", f);
        q = {8'hA5, 8'($urandom)};
        foreach (q[i]) send_byte(q[i], $urandom_range(0, 2));
        baud_run(4100);
      end else begin
        $display("[TB] random %0d: stray ack", f);
        do_ack(1'b0, 8'h00);
      end
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
